// File: rtl/vmem_arb_pkg.sv
// Shared types and constants for the video-RAM arbiter.
package vmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, PEND, RD_WAIT, ACK} state_t;

  localparam int AW_DEF     = 16;
  localparam int DW_DEF     = 8;
  localparam int RAM_RD_LAT = 1;
  // Grant -> RAM read -> output register
  localparam int VID_STAGES = RAM_RD_LAT + 1;
endpackage

// File: rtl/vmem_arb_stat.sv
// Saturating 32-bit accumulator of CPU cycles stalled behind scanout.
module vmem_arb_stat (
  input  logic        pixclk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] total
);
  logic [31:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (inc && (total_q != '1)) total_d = total_q + 32'd1;
  end

  always_ff @(posedge pixclk) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign total = total_q;
endmodule

// File: rtl/vmem_arbiter.sv
// Single-port video-RAM arbiter: scanout reads always win, CPU accesses fill idle slots.
// Optional VMEM_ARB_STAT_EN adds the stat_wait_total stall accumulator output.
module vmem_arbiter
  import vmem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 1023
) (
  input  logic          pixclk,
  input  logic          rst,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_starved,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef VMEM_ARB_STAT_EN
  ,
  output logic [31:0]   stat_wait_total
`endif
);
  localparam logic [AW-1:0] STARVE_LIM = AW'(STARVE_LIMIT);

  state_t state_q, state_d;
  logic                 cpu_we_q, cpu_we_d;
  logic [AW-1:0]        cpu_addr_q, cpu_addr_d;
  logic [DW-1:0]        cpu_wdata_q, cpu_wdata_d;
  logic [AW-1:0]        wait_q, wait_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic [VID_STAGES:1]  vld_pipe_q, vld_pipe_d;
  logic [DW-1:0]        vid_data_q, vid_data_d;
  logic                 vid_valid_q, vid_valid_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic [DW-1:0]        cpu_rdata_q, cpu_rdata_d;
  logic                 cpu_starved_q, cpu_starved_d;

  always_comb begin
    state_d     = state_q;
    cpu_we_d    = cpu_we_q;
    cpu_addr_d  = cpu_addr_q;
    cpu_wdata_d = cpu_wdata_q;
    wait_d      = wait_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vld_pipe_d  = {vld_pipe_q[VID_STAGES-1:1], vid_req};
    vid_valid_d = vld_pipe_q[VID_STAGES];
    vid_data_d  = vld_pipe_q[VID_STAGES] ? mem_rdata : vid_data_q;
    cpu_ack_d   = (state_q == ACK);

    if (vid_req) mem_addr_d = vid_addr;

    case (state_q)
      IDLE: if (cpu_req) begin
        cpu_we_d    = cpu_we;
        cpu_addr_d  = cpu_addr;
        cpu_wdata_d = cpu_wdata;
        wait_d      = '0;
        state_d     = PEND;
      end
      PEND: if (vid_req) begin
        if (wait_q != '1) wait_d = wait_q + AW'(1);
      end else begin
        mem_addr_d  = cpu_addr_q;
        mem_we_d    = cpu_we_q;
        mem_wdata_d = cpu_wdata_q;
        state_d     = cpu_we_q ? ACK : RD_WAIT;
      end
      RD_WAIT: state_d = ACK;
      // RAM output for the CPU address is present during ACK; capture it
      // alongside the ack so cpu_rdata is valid exactly while cpu_ack=1.
      ACK: begin
        if (!cpu_we_q) cpu_rdata_d = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cpu_starved_d = (state_d == PEND) && (wait_d > STARVE_LIM);
  end

  always_ff @(posedge pixclk) begin
    if (rst) begin
      state_q       <= IDLE;
      cpu_we_q      <= 1'b0;
      cpu_addr_q    <= '0;
      cpu_wdata_q   <= '0;
      wait_q        <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      vld_pipe_q    <= '0;
      vid_data_q    <= '0;
      vid_valid_q   <= 1'b0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_starved_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_we_q      <= cpu_we_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_wdata_q   <= cpu_wdata_d;
      wait_q        <= wait_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      vld_pipe_q    <= vld_pipe_d;
      vid_data_q    <= vid_data_d;
      vid_valid_q   <= vid_valid_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_starved_q <= cpu_starved_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign vid_data    = vid_data_q;
  assign vid_valid   = vid_valid_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_starved = cpu_starved_q;

`ifdef VMEM_ARB_STAT_EN
  vmem_arb_stat u_stat (
    .pixclk (pixclk),
    .rst    (rst),
    .inc    ((state_q == PEND) && vid_req),
    .total  (stat_wait_total)
  );
`endif
endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench for vmem_arbiter: CPU transaction table plus hand sequences.
module tb_vmem_arbiter;
  logic        pixclk = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_starved;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
`ifdef VMEM_ARB_STAT_EN
  logic [31:0] stat_wait_total;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram [0:65535];
  logic [7:0] shadow [logic [15:0]];
  logic [7:0] vq [$];

  always #5 pixclk = ~pixclk;

  vmem_arbiter #(.AW(16), .DW(8), .STARVE_LIMIT(4)) dut (
    .pixclk      (pixclk),
    .rst         (rst),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_data    (vid_data),
    .vid_valid   (vid_valid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cpu_starved (cpu_starved),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
`ifdef VMEM_ARB_STAT_EN
    ,
    .stat_wait_total (stat_wait_total)
`endif
  );

  // Synchronous single-port RAM, one-cycle read latency
  always @(posedge pixclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] exp_mem(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return pat(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pixclk);
    #1;
  endtask

  // Video scoreboard: each granted scanout read must come back in order
  always @(negedge pixclk) begin
    if (vid_valid) begin
      if (vq.size() == 0) check("vid_unexpected", 32'(vid_valid), 32'd0);
      else check("vid_data", 32'(vid_data), 32'(vq.pop_front()));
    end
  end

  task automatic drive_vid(input logic req, input logic [15:0] a);
    vid_req  = req;
    vid_addr = a;
    if (req) vq.push_back(exp_mem(a));
  endtask

  // One CPU transaction; scanout holds the bus for 'stall' edges after acceptance
  task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                        input int stall, input logic [15:0] vbase,
                        output int lat, output logic [7:0] rdata);
    bit got = 0;
    lat = 0;
    rdata = 8'h00;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (we) shadow[addr] = wdata;
    for (int k = 1; k <= 60 && !got; k++) begin
      drive_vid((k >= 2) && (k <= stall + 1), vbase + 16'(k));
      step();
      if (vid_req) check("mem_addr_vid", 32'(mem_addr), 32'(vid_addr));
      if (k == stall + 2) begin
        check("mem_addr_cpu", 32'(mem_addr), 32'(addr));
        if (we) check("mem_wdata", 32'(mem_wdata), 32'(wdata));
      end
      check("mem_we", 32'(mem_we), 32'((k == stall + 2) && we));
      check("cpu_starved", 32'(cpu_starved), 32'((k <= stall + 1) && (k - 1 > 4)));
      if (cpu_ack) begin
        got = 1;
        lat = k;
        rdata = cpu_rdata;
        cpu_req = 1'b0;
      end
    end
    drive_vid(1'b0, 16'h0);
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          stall;
    int          exp_lat;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int lat;
    logic [7:0] rd;

    tbl[0] = '{1'b1, 16'h1234, 8'h5A, 0,  3,  8'h00};
    tbl[1] = '{1'b0, 16'h1234, 8'h00, 0,  4,  8'h5A};
    tbl[2] = '{1'b0, 16'h0200, 8'h00, 20, 24, 8'hA7};
    tbl[3] = '{1'b1, 16'h0200, 8'hC3, 10, 13, 8'h00};
    tbl[4] = '{1'b0, 16'h0200, 8'h00, 2,  6,  8'hC3};
    tbl[5] = '{1'b1, 16'hFFFF, 8'h01, 0,  3,  8'h00};
    tbl[6] = '{1'b0, 16'hFFFF, 8'h00, 1,  5,  8'h01};
    tbl[7] = '{1'b0, 16'h0000, 8'h00, 0,  4,  8'hA5};

    for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
    ram[16'h0010] = 8'h41;
    shadow[16'h0010] = 8'h41;

    rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step(); step();
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_vid_data", 32'(vid_data), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_cpu_starved", 32'(cpu_starved), 32'd0);
`ifdef VMEM_ARB_STAT_EN
    check("rst_stat", stat_wait_total, 32'd0);
`endif
    rst = 1'b0;
    step();

    // Single scanout read: 2-edge latency
    drive_vid(1'b1, 16'h0010);
    step();
    check("vid_mem_addr", 32'(mem_addr), 32'h10);
    check("vid_mem_we", 32'(mem_we), 32'd0);
    check("vid_valid_n0", 32'(vid_valid), 32'd0);
    drive_vid(1'b0, 16'h0);
    step();
    check("vid_valid_n1", 32'(vid_valid), 32'd0);
    step();
    check("vid_valid_n2", 32'(vid_valid), 32'd1);
    check("vid_data_n2", 32'(vid_data), 32'h41);
    // Full-throughput burst
    for (int i = 0; i < 8; i++) begin
      drive_vid(1'b1, 16'h2000 + 16'(i * 3));
      step();
      check("burst_mem_we", 32'(mem_we), 32'd0);
    end
    drive_vid(1'b0, 16'h0);
    step(); step(); step();

    // Reset while a write is pending: abandoned, then re-accepted
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'h77;
    drive_vid(1'b0, 16'h0);
    step();
    drive_vid(1'b1, 16'h3100);
    step();
    check("pend_no_ack", 32'(cpu_ack), 32'd0);
    drive_vid(1'b1, 16'h3101);
    step();
    check("pend_mem_we", 32'(mem_we), 32'd0);
    rst = 1'b1;
    drive_vid(1'b0, 16'h0);
    step();
    vq.delete();
    check("rstp_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rstp_mem_we", 32'(mem_we), 32'd0);
    check("rstp_vid_valid", 32'(vid_valid), 32'd0);
`ifdef VMEM_ARB_STAT_EN
    check("rstp_stat", stat_wait_total, 32'd0);
`endif
    rst = 1'b0;
    cpu_op(1'b1, 16'h0400, 8'h77, 0, 16'h3200, lat, rd);
    check("rstp_relat", 32'(lat), 32'd3);
    cpu_op(1'b0, 16'h0400, 8'h00, 3, 16'h3300, lat, rd);
    check("rstp_rd_lat", 32'(lat), 32'd7);
    check("rstp_rd_data", 32'(rd), 32'h77);
    cpu_op(1'b1, 16'h0500, 8'h11, 4, 16'h3400, lat, rd);
    check("stall4_lat", 32'(lat), 32'd7);
`ifdef VMEM_ARB_STAT_EN
    step();
    check("stat_total", stat_wait_total, 32'd7);
`endif

    for (int i = 0; i < 8; i++) begin
      cpu_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].stall,
             16'h4000 + 16'(i * 64), lat, rd);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rdata));
      step();
      check($sformatf("tbl%0d_ack_pulse", i), 32'(cpu_ack), 32'd0);
    end

    step(); step(); step();
    check("vid_queue_drained", 32'(vq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
